mc_sequencer: RTL and testbench

- Parametrised multicycle instruction sequencer; next-generation replacement for the fixed main/floating-point decoder FSM pair in the core controller.
- Sequences fetch, decode, execute, writeback and PC update.
- Launches any of NUNIT variable-latency units (FPU, UART, divider, data memory) over a uniform go/valid handshake.
- Adds a per-instruction watchdog, illegal-unit detection and a retired-instruction counter.

---
 rtl/mc_sequencer.sv | 154 +++++++++++++++
 tb/tb_mc_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multicycle instruction sequencer: fetch/decode/exec/wait/writeback/PC update,
// with a go/valid handshake to NUNIT variable-latency units, a watchdog and a retire counter.
module mc_sequencer #(
    parameter int NUNIT   = 4,
    parameter int TIMEOUT = 1023,
    parameter int CNTW    = 32,
    parameter int UW      = (NUNIT > 1) ? $clog2(NUNIT) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mem_ready,
    input  logic             dec_useunit,
    input  logic [UW-1:0]    dec_unit,
    input  logic             dec_wb,
    input  logic             dec_fwb,
    input  logic             dec_branch,
    input  logic             taken,
    input  logic [NUNIT-1:0] unit_valid,
    input  logic             err_clr,
    output logic             fetch_req,
    output logic             irwrite,
    output logic             regwrite,
    output logic             fregwrite,
    output logic             pcen,
    output logic [NUNIT-1:0] unit_go,
    output logic             busy,
    output logic             timeout_err,
    output logic             illegal_err,
    output logic [CNTW-1:0]  retired,
    output logic [2:0]       state
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WAIT   = 3'd3,
        S_WB     = 3'd4,
        S_PCUPD  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_useunit;
    logic [UW-1:0]    r_unit;
    logic             r_wb;
    logic             r_fwb;
    logic             r_branch;
    logic [WDW-1:0]   r_wdog;
    logic [CNTW-1:0]  r_retired;
    logic             r_timeout_err;
    logic             r_illegal_err;
    logic [NUNIT-1:0] w_sel;
    logic             w_valid;
    logic             w_illegal;
    logic             w_timeout;

    // One-hot decode of the latched unit index; avoids out-of-range indexing.
    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NUNIT; i++) begin
            w_sel[i] = (r_unit == UW'(i));
        end
    end

    assign w_valid   = |(unit_valid & w_sel);
    assign w_illegal = dec_useunit && (32'(dec_unit) >= 32'(NUNIT));
    assign w_timeout = (r_state == S_WAIT) && !w_valid && (r_wdog == WDW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_illegal)              w_next = S_PCUPD;
                else if (dec_useunit)       w_next = S_EXEC;
                else if (dec_wb || dec_fwb) w_next = S_WB;
                else                        w_next = S_PCUPD;
            end
            S_EXEC:   w_next = S_WAIT;
            S_WAIT: begin
                if (w_valid)        w_next = (r_wb || r_fwb) ? S_WB : S_PCUPD;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_WB:     w_next = S_PCUPD;
            S_PCUPD:  w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_useunit <= 1'b0;
            r_unit    <= '0;
            r_wb      <= 1'b0;
            r_fwb     <= 1'b0;
            r_branch  <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_useunit <= dec_useunit;
            r_unit    <= dec_unit;
            r_wb      <= dec_wb;
            r_fwb     <= dec_fwb;
            r_branch  <= dec_branch;
        end
    end

    // Watchdog saturates at TIMEOUT so it can never wrap back to a small count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wdog <= '0;
        end else if (r_state == S_EXEC) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT && !w_valid && r_wdog != WDW'(TIMEOUT)) begin
            r_wdog <= r_wdog + WDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_retired     <= '0;
            r_timeout_err <= 1'b0;
            r_illegal_err <= 1'b0;
        end else begin
            if (r_state == S_PCUPD) r_retired <= r_retired + CNTW'(1);
            r_timeout_err <= w_timeout || (r_timeout_err && !err_clr);
            r_illegal_err <= ((r_state == S_DECODE) && w_illegal) || (r_illegal_err && !err_clr);
        end
    end

    // Fetch strobes are gated by rstn so every output reads 0 while reset is held.
    assign fetch_req   = rstn && (r_state == S_FETCH);
    assign irwrite     = rstn && (r_state == S_FETCH) && mem_ready;
    assign regwrite    = (r_state == S_WB) && r_wb;
    assign fregwrite   = (r_state == S_WB) && r_fwb;
    assign pcen        = (r_state == S_PCUPD) && (!r_branch || taken);
    assign unit_go     = (r_state == S_EXEC) ? w_sel : '0;
    assign busy        = (r_state == S_EXEC) || (r_state == S_WAIT);
    assign timeout_err = r_timeout_err;
    assign illegal_err = r_illegal_err;
    assign retired     = r_retired;
    assign state       = r_state;

    logic w_unused;
    assign w_unused = r_useunit;
endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: table vectors, randomized instructions against a
// per-instruction trace model, and hand sequences for reset, watchdog and wrap.
module tb_mc_sequencer;
    localparam int A_NUNIT = 4;
    localparam int A_TMO   = 20;
    localparam int A_CNTW  = 16;
    localparam int B_NUNIT = 3;
    localparam int B_TMO   = 5;
    localparam int B_CNTW  = 4;

    typedef struct packed {
        logic [7:0] cycles;
        logic [3:0] irw;
        logic [3:0] rw;
        logic [3:0] frw;
        logic [3:0] pc;
        logic [3:0] go_cnt;
        logic [3:0] go_or;
        logic [7:0] busy;
    } summ_t;

    typedef struct {
        bit       useunit;
        bit [1:0] unit;
        bit       wb;
        bit       fwb;
        bit       branch;
        bit       taken;
        bit       spur;
        int       md;
        int       vd;
    } instr_t;

    typedef struct {
        instr_t ins;
        summ_t  exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       mem_ready = 1'b0;
    logic       dec_useunit = 1'b0;
    logic [1:0] dec_unit = '0;
    logic       dec_wb = 1'b0;
    logic       dec_fwb = 1'b0;
    logic       dec_branch = 1'b0;
    logic       taken = 1'b0;
    logic [3:0] unit_valid = '0;
    logic       err_clr = 1'b0;

    logic              a_fetch_req, a_irwrite, a_regwrite, a_fregwrite, a_pcen, a_busy;
    logic              a_timeout_err, a_illegal_err;
    logic [3:0]        a_unit_go;
    logic [A_CNTW-1:0] a_retired;
    logic [2:0]        a_state;
    logic              b_fetch_req, b_irwrite, b_regwrite, b_fregwrite, b_pcen, b_busy;
    logic              b_timeout_err, b_illegal_err;
    logic [2:0]        b_unit_go;
    logic [B_CNTW-1:0] b_retired;
    logic [2:0]        b_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [A_CNTW-1:0] m_ret = '0;
    bit m_tmo = 1'b0;
    bit m_ill = 1'b0;

    always #5 clk = ~clk;

    mc_sequencer #(.NUNIT(A_NUNIT), .TIMEOUT(A_TMO), .CNTW(A_CNTW)) u_a (
        .clk(clk), .rstn(rstn), .mem_ready(mem_ready), .dec_useunit(dec_useunit),
        .dec_unit(dec_unit), .dec_wb(dec_wb), .dec_fwb(dec_fwb), .dec_branch(dec_branch),
        .taken(taken), .unit_valid(unit_valid), .err_clr(err_clr),
        .fetch_req(a_fetch_req), .irwrite(a_irwrite), .regwrite(a_regwrite),
        .fregwrite(a_fregwrite), .pcen(a_pcen), .unit_go(a_unit_go), .busy(a_busy),
        .timeout_err(a_timeout_err), .illegal_err(a_illegal_err), .retired(a_retired),
        .state(a_state)
    );

    mc_sequencer #(.NUNIT(B_NUNIT), .TIMEOUT(B_TMO), .CNTW(B_CNTW)) u_b (
        .clk(clk), .rstn(rstn), .mem_ready(mem_ready), .dec_useunit(dec_useunit),
        .dec_unit(dec_unit), .dec_wb(dec_wb), .dec_fwb(dec_fwb), .dec_branch(dec_branch),
        .taken(taken), .unit_valid(unit_valid[2:0]), .err_clr(err_clr),
        .fetch_req(b_fetch_req), .irwrite(b_irwrite), .regwrite(b_regwrite),
        .fregwrite(b_fregwrite), .pcen(b_pcen), .unit_go(b_unit_go), .busy(b_busy),
        .timeout_err(b_timeout_err), .illegal_err(b_illegal_err), .retired(b_retired),
        .state(b_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk_ins(input bit u, input bit [1:0] un, input bit wb, input bit fwb,
                                      input bit br, input bit tk, input bit sp, input int md,
                                      input int vd);
        instr_t i;
        i.useunit = u; i.unit = un; i.wb = wb; i.fwb = fwb; i.branch = br;
        i.taken = tk; i.spur = sp; i.md = md; i.vd = vd;
        return i;
    endfunction

    function automatic summ_t mk_sum(input int cyc, input int irw, input int rw, input int frw,
                                     input int pc, input int gc, input logic [3:0] gor,
                                     input int bsy);
        summ_t s;
        s.cycles = 8'(cyc); s.irw = 4'(irw); s.rw = 4'(rw); s.frw = 4'(frw);
        s.pc = 4'(pc); s.go_cnt = 4'(gc); s.go_or = gor; s.busy = 8'(bsy);
        return s;
    endfunction

    // Expected per-instruction trace derived from the state-by-state cycle budget.
    function automatic summ_t model(input instr_t i, input int nunit, input int tmo_lim,
                                    output bit ev_ret, output bit ev_tmo, output bit ev_ill);
        summ_t s;
        s = '0;
        ev_ret = 1'b0; ev_tmo = 1'b0;
        s.cycles = 8'(i.md + 2);
        s.irw = 4'd1;
        ev_ill = i.useunit && (int'(i.unit) >= nunit);
        if (i.useunit && !ev_ill) begin
            s.go_cnt = 4'd1;
            s.go_or = 4'(1 << i.unit);
            if (i.vd >= tmo_lim) begin
                s.cycles = s.cycles + 8'(1 + tmo_lim);
                s.busy = 8'(1 + tmo_lim);
                ev_tmo = 1'b1;
                return s;
            end
            s.cycles = s.cycles + 8'(i.vd + 2);
            s.busy = 8'(i.vd + 2);
        end
        if (!ev_ill && (i.wb || i.fwb)) begin
            s.cycles++;
            s.rw = 4'(i.wb);
            s.frw = 4'(i.fwb);
        end
        s.cycles++;
        s.pc = 4'(!i.branch || i.taken);
        ev_ret = 1'b1;
        return s;
    endfunction

    // Runs one instruction on DUT A from a FETCH cycle (entered at posedge+1).
    task automatic run_instr(input instr_t ins, output summ_t s);
        bit left, gone, done;
        int w;
        s = '0;
        left = 0; gone = 0; done = 0; w = 0;
        dec_useunit = ins.useunit; dec_unit = ins.unit; dec_wb = ins.wb; dec_fwb = ins.fwb;
        dec_branch = ins.branch; taken = ins.taken;
        unit_valid = '0;
        mem_ready = (ins.md == 0);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            s.cycles++;
            if (a_irwrite) s.irw++;
            if (a_regwrite) s.rw++;
            if (a_fregwrite) s.frw++;
            if (a_pcen) s.pc++;
            if (a_busy) s.busy++;
            if (a_unit_go != 4'd0) begin
                s.go_cnt++;
                s.go_or = s.go_or | a_unit_go;
            end
            @(posedge clk); #1;
            if (a_state != 3'd0) left = 1;
            else if (left) done = 1;
            mem_ready = (cyc + 1 >= ins.md);
            if (s.go_cnt != 4'd0) gone = 1;
            unit_valid = '0;
            if (gone) begin
                if (w == ins.vd) unit_valid[ins.unit] = 1'b1;
                else if (ins.spur && w == 0) unit_valid[ins.unit + 2'd2] = 1'b1;
                w++;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_bound: instruction did not return to FETCH within 200 cycles");
        end
    endtask

    task automatic apply(input instr_t ins, input summ_t exp, input string tag);
        summ_t got, mexp;
        bit er, et, ei;
        mexp = model(ins, A_NUNIT, A_TMO, er, et, ei);
        run_instr(ins, got);
        if (er) m_ret++;
        m_tmo = m_tmo | et;
        m_ill = m_ill | ei;
        check({tag, "_trace"}, 64'(got), 64'(exp));
        check({tag, "_retired"}, 64'(a_retired), 64'(m_ret));
        check({tag, "_flags"}, 64'({a_timeout_err, a_illegal_err}), 64'({m_tmo, m_ill}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t  tbl[10];
        summ_t e;
        bit    d0, d1, d2;
        int    waitc, pcc, rwc;
        bit    left;
        logic [3:0] gor;
        logic [2:0] exp3;

        tbl[0] = '{ins: mk_ins(0, 0, 0, 0, 0, 0, 0, 0, 0),  exp: mk_sum(3, 1, 0, 0, 1, 0, 4'b0000, 0)};
        tbl[1] = '{ins: mk_ins(0, 0, 1, 0, 0, 0, 0, 0, 0),  exp: mk_sum(4, 1, 1, 0, 1, 0, 4'b0000, 0)};
        tbl[2] = '{ins: mk_ins(0, 0, 1, 1, 0, 0, 0, 1, 0),  exp: mk_sum(5, 1, 1, 1, 1, 0, 4'b0000, 0)};
        tbl[3] = '{ins: mk_ins(0, 0, 0, 0, 1, 0, 0, 0, 0),  exp: mk_sum(3, 1, 0, 0, 0, 0, 4'b0000, 0)};
        tbl[4] = '{ins: mk_ins(0, 0, 0, 0, 1, 1, 0, 0, 0),  exp: mk_sum(3, 1, 0, 0, 1, 0, 4'b0000, 0)};
        tbl[5] = '{ins: mk_ins(1, 2, 0, 1, 0, 0, 1, 0, 6),  exp: mk_sum(12, 1, 0, 1, 1, 1, 4'b0100, 8)};
        tbl[6] = '{ins: mk_ins(1, 0, 0, 0, 0, 0, 0, 2, 0),  exp: mk_sum(7, 1, 0, 0, 1, 1, 4'b0001, 2)};
        tbl[7] = '{ins: mk_ins(1, 3, 1, 0, 1, 0, 1, 0, 3),  exp: mk_sum(9, 1, 1, 0, 0, 1, 4'b1000, 5)};
        tbl[8] = '{ins: mk_ins(1, 1, 0, 0, 0, 0, 0, 0, 19), exp: mk_sum(24, 1, 0, 0, 1, 1, 4'b0010, 21)};
        tbl[9] = '{ins: mk_ins(1, 1, 1, 0, 0, 0, 0, 0, 20), exp: mk_sum(23, 1, 0, 0, 0, 1, 4'b0010, 21)};

        // Reset state, with mem_ready high to show irwrite stays low in reset.
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_a",
              64'({a_fetch_req, a_irwrite, a_regwrite, a_fregwrite, a_pcen, a_busy,
                   a_timeout_err, a_illegal_err, a_unit_go, a_state}), 64'(0));
        check("reset_retired_a", 64'(a_retired), 64'(0));
        check("reset_outputs_b", 64'({b_fetch_req, b_irwrite, b_unit_go, b_state, b_retired}), 64'(0));
        mem_ready = 1'b0;
        rstn = 1'b1;

        // Back-to-back ALU writeback instructions: 4-cycle cadence.
        @(posedge clk); #1;
        mem_ready = 1'b1; dec_wb = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            exp3 = (c % 4 == 0) ? 3'b100 : (c % 4 == 2) ? 3'b010 : (c % 4 == 3) ? 3'b001 : 3'b000;
            check($sformatf("alu_strobes_c%0d", c), 64'({a_irwrite, a_regwrite, a_pcen}), 64'(exp3));
            @(posedge clk); #1;
        end
        check("alu_retired_10", 64'(a_retired), 64'(10));

        // Reset asserted in the middle of WAIT.
        dec_useunit = 1'b1; dec_unit = 2'd1; dec_wb = 1'b1; unit_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("midwait_state", 64'(a_state), 64'(3));
        #2;
        rstn = 1'b0;
        #1;
        check("midwait_async_reset",
              64'({a_state, a_unit_go, a_busy, a_fetch_req, (a_retired != '0)}), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        mem_ready = 1'b0;
        unit_valid = 4'b0010;
        rwc = 0; gor = '0;
        repeat (10) begin
            @(negedge clk);
            if (a_regwrite || a_pcen) rwc++;
            gor = gor | a_unit_go;
        end
        check("midwait_no_resume", 64'({a_state, gor, 8'(rwc)}), 64'(0));
        unit_valid = '0;
        @(posedge clk); #1;

        // Table vectors, then randomized instructions against the model.
        for (int k = 0; k < 10; k++) begin
            apply(tbl[k].ins, tbl[k].exp, $sformatf("vec%0d", k));
        end
        for (int k = 0; k < 60; k++) begin
            instr_t r;
            r = mk_ins(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 23))
                                                   : int'($urandom_range(0, 5)));
            e = model(r, A_NUNIT, A_TMO, d0, d1, d2);
            apply(r, e, $sformatf("rand%0d", k));
        end

        // DUT B: watchdog with TIMEOUT=5.
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
        @(posedge clk); #1;
        dec_useunit = 1'b1; dec_unit = 2'd1; dec_wb = 1'b0; dec_fwb = 1'b0; dec_branch = 1'b0;
        unit_valid = '0; mem_ready = 1'b1;
        waitc = 0; pcc = 0; left = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (b_state == 3'd3) waitc++;
            if (b_pcen) pcc++;
            if (b_state != 3'd0) left = 1;
            else if (left) break;
        end
        mem_ready = 1'b0;
        check("wdog_wait_cycles", 64'(waitc), 64'(5));
        check("wdog_flag_set", 64'(b_timeout_err), 64'(1));
        check("wdog_no_retire", 64'({b_retired, 4'(pcc)}), 64'(0));
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("wdog_flag_clr", 64'(b_timeout_err), 64'(0));

        // DUT B: illegal unit index 3 with NUNIT=3, err_clr colliding with the set.
        dec_useunit = 1'b1; dec_unit = 2'd3; dec_wb = 1'b1; mem_ready = 1'b1;
        gor = '0; pcc = 0; rwc = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            gor = gor | {1'b0, b_unit_go};
            if (b_pcen) pcc++;
            if (b_regwrite) rwc++;
            @(posedge clk); #1;
            err_clr = (c == 0);
        end
        err_clr = 1'b0;
        check("illegal_flag_set_wins", 64'(b_illegal_err), 64'(1));
        check("illegal_no_go_no_wb", 64'({gor, 8'(rwc)}), 64'(0));
        check("illegal_pcen_once", 64'(pcc), 64'(1));
        check("illegal_retired", 64'(b_retired), 64'(1));

        // Retire counter wrap at CNTW=4.
        dec_useunit = 1'b0; dec_wb = 1'b0;
        repeat (14 * 3) @(posedge clk);
        #1;
        check("retired_15", 64'(b_retired), 64'(15));
        repeat (3) @(posedge clk);
        #1;
        check("retired_wrap_0", 64'(b_retired), 64'(0));
        mem_ready = 1'b0;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("illegal_flag_clr", 64'(b_illegal_err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
